// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sort_pkg
//  Purpose : Shared constants and fill-state encoding for the sorter path
//            (frame loader and sorter FSM).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package sort_pkg;

   localparam int DATA_W    = 64;
   localparam int FRAME_LEN = 8;
   localparam int ADDR_W    = $clog2(FRAME_LEN);

   // All-ones filler sorts after every real word.
   localparam logic [DATA_W-1:0] PAD_WORD = '1;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      PAD   = 2'd1,
      STALL = 2'd2
   } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_bank.sv
`default_nettype none
// ============================================================================
//  Module  : frame_bank
//  Purpose : FRAME_LEN x DATA_W frame storage, one synchronous write port and
//            one registered read port (1-cycle read latency).
//  Ports   : clk, rst        clock, sync active-high reset (read register)
//            i_we/i_waddr/i_wdata   write port
//            i_raddr/o_rdata        registered read port
//  Rev     : 1.0  initial release
// ============================================================================
module frame_bank
   import sort_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [FRAME_LEN];
   logic [DATA_W-1:0] r_rdata;

   // Storage contents are don't-care after reset, so no reset on the array.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sort_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module  : sort_frame_loader
//  Purpose : Packs a valid/ready word stream into FRAME_LEN-word frames held
//            in a ping-pong pair of banks; short frames are padded with
//            PAD_WORD. Completed frames are offered to the sorter through a
//            frame_valid/frame_done handshake and a registered read port.
//  Ports   : clk, rst                 clock, sync active-high reset
//            s_data/s_valid/s_last    input stream, s_ready back-pressure
//            frame_valid, frame_len   read bank holds a frame of frame_len words
//            rd_addr -> rd_data       read port, 1-cycle latency
//            frame_done               sorter releases the read bank
//  Rev     : 1.0  initial release
// ============================================================================
module sort_frame_loader
   import sort_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic              frame_valid,
   output logic [ADDR_W:0]   frame_len,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              frame_done
);

   localparam logic [ADDR_W-1:0] c_LAST_PTR = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W:0]   c_FULL_LEN = (ADDR_W + 1)'(FRAME_LEN);

   fill_state_t       r_state, w_state_n;
   logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_n;
   logic              r_wr_bank, w_wr_bank_n;
   logic              r_rd_bank, w_rd_bank_n;
   logic              r_rd_sel;
   logic [1:0]        r_full, w_full_n;
   logic [ADDR_W:0]   r_len [2];
   logic [ADDR_W:0]   w_len_n [2];
   logic [ADDR_W:0]   r_pad_len, w_pad_len_n;
   logic [ADDR_W:0]   w_close_len;
   logic              r_frame_valid;
   logic [ADDR_W:0]   r_frame_len;
   logic              r_rst_d;
   logic              w_accept, w_done, w_close, w_we;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_q [2];

   // Held low for one extra cycle after reset releases.
   assign s_ready  = (r_state == FILL) && !r_rst_d && !rst;
   assign w_accept = s_valid && s_ready;
   // A release is only meaningful while a frame is actually presented.
   assign w_done   = frame_done && r_frame_valid;

   always_comb begin
      w_state_n   = r_state;
      w_wr_ptr_n  = r_wr_ptr;
      w_wr_bank_n = r_wr_bank;
      w_rd_bank_n = r_rd_bank;
      w_full_n    = r_full;
      w_len_n     = r_len;
      w_pad_len_n = r_pad_len;
      w_we        = 1'b0;
      w_wdata     = s_data;
      w_close     = 1'b0;
      w_close_len = r_pad_len;

      case (r_state)
         FILL: begin
            if (w_accept) begin
               w_we       = 1'b1;
               w_wr_ptr_n = r_wr_ptr + ADDR_W'(1);
               if (r_wr_ptr == c_LAST_PTR) begin
                  w_close     = 1'b1;
                  w_close_len = c_FULL_LEN;
               end else if (s_last) begin
                  w_state_n   = PAD;
                  w_pad_len_n = {1'b0, r_wr_ptr} + (ADDR_W + 1)'(1);
               end
            end
         end
         PAD: begin
            w_we       = 1'b1;
            w_wdata    = PAD_WORD;
            w_wr_ptr_n = r_wr_ptr + ADDR_W'(1);
            if (r_wr_ptr == c_LAST_PTR) begin
               w_close = 1'b1;
            end
         end
         STALL: begin
            // Resolved below once this cycle's release is known.
         end
         default: begin
            w_state_n = FILL;
         end
      endcase

      // Release is applied first so a close in the same cycle sees the
      // freed bank and avoids a stall.
      if (w_done) begin
         w_full_n[r_rd_bank] = 1'b0;
         w_rd_bank_n         = !r_rd_bank;
      end

      if (w_close) begin
         w_full_n[r_wr_bank] = 1'b1;
         w_len_n[r_wr_bank]  = w_close_len;
         w_wr_bank_n         = !r_wr_bank;
         w_state_n           = w_full_n[!r_wr_bank] ? STALL : FILL;
      end

      if ((r_state == STALL) && !w_full_n[r_wr_bank]) begin
         w_state_n = FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= FILL;
         r_wr_ptr      <= '0;
         r_wr_bank     <= 1'b0;
         r_rd_bank     <= 1'b0;
         r_rd_sel      <= 1'b0;
         r_full        <= '0;
         r_len         <= '{default: '0};
         r_pad_len     <= '0;
         r_frame_valid <= 1'b0;
         r_frame_len   <= '0;
         r_rst_d       <= 1'b1;
      end else begin
         r_state       <= w_state_n;
         r_wr_ptr      <= w_wr_ptr_n;
         r_wr_bank     <= w_wr_bank_n;
         r_rd_bank     <= w_rd_bank_n;
         r_rd_sel      <= r_rd_bank;
         r_full        <= w_full_n;
         r_len         <= w_len_n;
         r_pad_len     <= w_pad_len_n;
         r_rst_d       <= 1'b0;
         // The read bank's length cannot change while it is full, so this
         // keeps frame_len stable for the whole presentation.
         r_frame_valid <= w_full_n[w_rd_bank_n];
         if (w_full_n[w_rd_bank_n]) begin
            r_frame_len <= w_len_n[w_rd_bank_n];
         end
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      frame_bank u_bank (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_we && (r_wr_bank == 1'(gi))),
         .i_waddr (r_wr_ptr),
         .i_wdata (w_wdata),
         .i_raddr (rd_addr),
         .o_rdata (w_q[gi])
      );
   end

   // Select follows the bank that owned the read when the address was
   // sampled, so a release does not redirect an in-flight read.
   assign rd_data     = r_rd_sel ? w_q[1] : w_q[0];
   assign frame_valid = r_frame_valid;
   assign frame_len   = r_frame_len;

endmodule
`default_nettype wire

// File: tb/tb_sort_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sort_frame_loader
//  Purpose : Self-checking bench for sort_frame_loader; expected frames come
//            from a queue-based model of the packing/padding rules.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sort_frame_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic        frame_valid;
   logic [3:0]  frame_len;
   logic [2:0]  rd_addr;
   logic [63:0] rd_data;
   logic        frame_done;

   sort_frame_loader dut (
      .clk         (clk),
      .rst         (rst),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .frame_valid (frame_valid),
      .frame_len   (frame_len),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] w [8];
      int          len;
   } frame_t;

   frame_t      exp_q [$];
   logic [63:0] cur_w [$];
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: frames close at 8 words or on s_last, padded with all ones.
   task automatic model_push(input logic [63:0] d, input logic last);
      frame_t f;
      cur_w.push_back(d);
      if (cur_w.size() == 8 || last) begin
         for (int i = 0; i < 8; i++) f.w[i] = (i < cur_w.size()) ? cur_w[i] : 64'hFFFF_FFFF_FFFF_FFFF;
         f.len = cur_w.size();
         exp_q.push_back(f);
         cur_w.delete();
      end
   endtask

   task automatic send(input logic [63:0] d, input logic last);
      int n = 0;
      s_data  = d;
      s_last  = last;
      s_valid = 1'b1;
      while (!s_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         chk("send_timeout", {63'd0, s_ready}, 64'd1);
      end else begin
         tick();
         model_push(d, last);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      s_valid    = 1'b0;
      s_last     = 1'b0;
      frame_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      cur_w.delete();
      exp_q.delete();
      #1;
   endtask

   task automatic read_frame(input string tag);
      frame_t f;
      int n = 0;
      while (!frame_valid && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {63'd0, frame_valid}, 64'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_model_empty"}, 64'd0, 64'd1);
      end else begin
         f = exp_q.pop_front();
         chk({tag, "_len"}, {60'd0, frame_len}, 64'(f.len));
         for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            tick();
            chk({tag, "_data"}, rd_data, f.w[a]);
         end
      end
   endtask

   task automatic release_frame();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
   endtask

   initial begin
      int cnt;
      logic fv_early;
      logic [63:0] d;
      int len;

      rd_addr = '0;
      s_data  = '0;
      do_reset();
      rst = 1'b1;
      tick();
      chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_frame_valid", {63'd0, frame_valid}, 64'd0);
      chk("rst_frame_len", {60'd0, frame_len}, 64'd0);
      chk("rst_rd_data", rd_data, 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_after1_s_ready", {63'd0, s_ready}, 64'd0);
      tick();
      chk("rst_after2_s_ready", {63'd0, s_ready}, 64'd1);

      // 1: full frame, continuous
      for (int i = 1; i <= 8; i++) begin
         chk("t1_ready", {63'd0, s_ready}, 64'd1);
         if (i == 8) chk("t1_fv_before", {63'd0, frame_valid}, 64'd0);
         send(64'(i), 1'b0);
      end
      s_valid = 1'b0;
      chk("t1_fv_after", {63'd0, frame_valid}, 64'd1);
      read_frame("t1");
      release_frame();

      // 2: short frame with padding
      send(64'hA, 1'b0);
      send(64'hB, 1'b0);
      send(64'hC, 1'b1);
      s_valid = 1'b0;
      s_last  = 1'b0;
      cnt = 0;
      fv_early = 1'b0;
      while (!s_ready && cnt < 20) begin
         fv_early |= frame_valid;
         cnt++;
         tick();
      end
      chk("t2_stall_cycles", 64'(cnt), 64'd5);
      chk("t2_fv_early", {63'd0, fv_early}, 64'd0);
      chk("t2_fv_rise", {63'd0, frame_valid}, 64'd1);
      read_frame("t2");
      release_frame();

      // 3: two frames, back-pressure on the 17th word
      for (int i = 1; i <= 16; i++) begin
         chk("t3_ready", {63'd0, s_ready}, 64'd1);
         send(64'(i), 1'b0);
      end
      s_data = 64'd17;
      for (int i = 0; i < 3; i++) begin
         chk("t3_stalled", {63'd0, s_ready}, 64'd0);
         tick();
      end
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      void'(exp_q.pop_front());
      chk("t3_ready_after_done", {63'd0, s_ready}, 64'd1);
      chk("t3_fv_kept", {63'd0, frame_valid}, 64'd1);
      rd_addr = 3'd0;
      tick();
      model_push(64'd17, 1'b0);
      s_valid = 1'b0;
      chk("t3_rd0", rd_data, 64'd9);
      read_frame("t3");
      release_frame();
      send(64'd18, 1'b0);
      send(64'd19, 1'b0);
      send(64'd20, 1'b0);
      s_valid = 1'b0;

      // 4: reset mid-frame discards the partial frame
      rst = 1'b1;
      tick();
      chk("t4_fv_in_rst", {63'd0, frame_valid}, 64'd0);
      chk("t4_ready_in_rst", {63'd0, s_ready}, 64'd0);
      rst = 1'b0;
      cur_w.delete();
      exp_q.delete();
      tick();
      chk("t4_fv_after_rst", {63'd0, frame_valid}, 64'd0);
      for (int i = 0; i < 8; i++) send(64'h100 + 64'(i), 1'b0);
      s_valid = 1'b0;
      read_frame("t4");
      release_frame();

      // 5: ignored frame_done while idle
      do_reset();
      tick();
      release_frame();
      chk("t5_ready", {63'd0, s_ready}, 64'd1);
      chk("t5_fv", {63'd0, frame_valid}, 64'd0);
      for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 1'b0);
      s_valid = 1'b0;
      chk("t5_fv_after", {63'd0, frame_valid}, 64'd1);
      read_frame("t5");
      release_frame();

      // 6: close coinciding with release of the other bank
      do_reset();
      tick();
      for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 1'b0);
      s_valid = 1'b0;
      read_frame("t6a");
      for (int i = 0; i < 7; i++) send({$urandom, $urandom}, 1'b0);
      d = {$urandom, $urandom};
      frame_done = 1'b1;
      send(d, 1'b0);
      frame_done = 1'b0;
      s_valid = 1'b0;
      chk("t6_ready", {63'd0, s_ready}, 64'd1);
      chk("t6_fv", {63'd0, frame_valid}, 64'd1);
      read_frame("t6b");
      release_frame();

      // Random pairs of frames with random lengths and input gaps
      for (int p = 0; p < 4; p++) begin
         for (int f = 0; f < 2; f++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
               send({$urandom, $urandom}, (i == len - 1) ? 1'b1 : 1'b0);
               s_valid = 1'b0;
               for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            end
         end
         read_frame("rnd_a");
         release_frame();
         read_frame("rnd_b");
         release_frame();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
